// File: rtl/rsa_stream_ctrl.sv
// Byte-stream initiator for the RSA decryption core: loads N, d and ciphertext
// blocks from an 8-bit rx stream, starts the core, and streams the plaintext back.
module rsa_stream_ctrl #(
  parameter int RSA_BIT_MAX = 1024,
  parameter int BYTE_CNT_W  = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [10:0]            i_RSA_bit,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_valid,
  output logic                   o_rx_ready,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready,
  output logic                   o_core_start,
  output logic [RSA_BIT_MAX-1:0] o_core_a,
  output logic [RSA_BIT_MAX-1:0] o_core_d,
  output logic [RSA_BIT_MAX-1:0] o_core_n,
  input  logic [RSA_BIT_MAX-1:0] i_core_a_pow_d,
  input  logic                   i_core_finished,
  output logic                   o_busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GET_N = 3'd1;
  localparam logic [2:0] S_GET_D = 3'd2;
  localparam logic [2:0] S_GET_A = 3'd3;
  localparam logic [2:0] S_START = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;
  localparam logic [2:0] S_SEND  = 3'd6;

  logic [2:0]             state;
  logic [BYTE_CNT_W-1:0]  bytes;
  logic [BYTE_CNT_W-1:0]  cnt;
  logic [BYTE_CNT_W-1:0]  size_bytes;
  logic [BYTE_CNT_W+2:0]  bit_idx;
  logic [RSA_BIT_MAX-1:0] n_reg;
  logic [RSA_BIT_MAX-1:0] d_reg;
  logic [RSA_BIT_MAX-1:0] a_reg;
  logic [RSA_BIT_MAX-1:0] pt_reg;
  logic                   armed;
  logic                   rx_fire;
  logic                   tx_fire;
  logic                   last_in;

  // NOTE: combinational blocks assign a default first so no path leaves the output unassigned (no latch).
  always_comb begin
    size_bytes = BYTE_CNT_W'(16);
    case (i_RSA_bit)
      11'd256:  size_bytes = BYTE_CNT_W'(32);
      11'd512:  size_bytes = BYTE_CNT_W'(64);
      11'd1024: size_bytes = BYTE_CNT_W'(128);
      default:  size_bytes = BYTE_CNT_W'(16);
    endcase
  end

  assign o_rx_ready   = (state == S_GET_N) || (state == S_GET_D) || (state == S_GET_A);
  assign o_tx_valid   = (state == S_SEND);
  assign o_core_start = (state == S_START);
  assign o_busy       = (state == S_START) || (state == S_WAIT);
  assign o_core_a     = a_reg;
  assign o_core_d     = d_reg;
  assign o_core_n     = n_reg;

  assign rx_fire = i_rx_valid && o_rx_ready;
  assign tx_fire = o_tx_valid && i_tx_ready;
  assign last_in = (cnt == bytes - BYTE_CNT_W'(1));
  assign bit_idx = {cnt, 3'b000};

  // Byte index BYTES-1 of the result is never selected, so it is simply dropped.
  assign o_tx_data = o_tx_valid ? pt_reg[bit_idx +: 8] : 8'h00;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the wide key/data registers are reset too, because the core buses must read 0 after an abort.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= S_IDLE;
      bytes  <= '0;
      cnt    <= '0;
      n_reg  <= '0;
      d_reg  <= '0;
      a_reg  <= '0;
      pt_reg <= '0;
      armed  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          bytes <= size_bytes;
          n_reg <= '0;
          cnt   <= '0;
          state <= S_GET_N;
        end
        S_GET_N: if (rx_fire) begin
          n_reg <= {n_reg[RSA_BIT_MAX-9:0], i_rx_data};
          if (last_in) begin
            d_reg <= '0;
            cnt   <= '0;
            state <= S_GET_D;
          end else begin
            cnt <= cnt + BYTE_CNT_W'(1);
          end
        end
        S_GET_D: if (rx_fire) begin
          d_reg <= {d_reg[RSA_BIT_MAX-9:0], i_rx_data};
          if (last_in) begin
            a_reg <= '0;
            cnt   <= '0;
            state <= S_GET_A;
          end else begin
            cnt <= cnt + BYTE_CNT_W'(1);
          end
        end
        S_GET_A: if (rx_fire) begin
          a_reg <= {a_reg[RSA_BIT_MAX-9:0], i_rx_data};
          if (last_in) begin
            cnt   <= '0;
            state <= S_START;
          end else begin
            cnt <= cnt + BYTE_CNT_W'(1);
          end
        end
        S_START: begin
          armed <= 1'b0;
          state <= S_WAIT;
        end
        // The core's finished flag may still be high from the previous block, so skip one cycle.
        S_WAIT: begin
          if (!armed) begin
            armed <= 1'b1;
          end else if (i_core_finished) begin
            pt_reg <= i_core_a_pow_d;
            cnt    <= bytes - BYTE_CNT_W'(2);
            state  <= S_SEND;
          end
        end
        S_SEND: if (tx_fire) begin
          if (cnt == '0) begin
            a_reg <= '0;
            state <= S_GET_A;
          end else begin
            cnt <= cnt - BYTE_CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_stream_ctrl.sv
// Directed bench for rsa_stream_ctrl: key load, stale-flag handling, backpressure,
// key reuse, 1024-bit operation with abort, and illegal key size.
module tb_rsa_stream_ctrl;

  localparam int W = 1024;

  logic         clk = 1'b0;
  logic         i_rst = 1'b0;
  logic [10:0]  i_RSA_bit = 11'd128;
  logic [7:0]   i_rx_data = 8'h00;
  logic         i_rx_valid = 1'b0;
  logic         o_rx_ready;
  logic [7:0]   o_tx_data;
  logic         o_tx_valid;
  logic         i_tx_ready = 1'b0;
  logic         o_core_start;
  logic [W-1:0] o_core_a, o_core_d, o_core_n;
  logic [W-1:0] i_core_a_pow_d = '0;
  logic         i_core_finished = 1'b1;
  logic         o_busy;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  rsa_stream_ctrl dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_RSA_bit      (i_RSA_bit),
    .i_rx_data      (i_rx_data),
    .i_rx_valid     (i_rx_valid),
    .o_rx_ready     (o_rx_ready),
    .o_tx_data      (o_tx_data),
    .o_tx_valid     (o_tx_valid),
    .i_tx_ready     (i_tx_ready),
    .o_core_start   (o_core_start),
    .o_core_a       (o_core_a),
    .o_core_d       (o_core_d),
    .o_core_n       (o_core_n),
    .i_core_a_pow_d (i_core_a_pow_d),
    .i_core_finished(i_core_finished),
    .o_busy         (o_busy)
  );

  // Presents one byte at a negedge and returns at the negedge after it transferred.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    while (o_rx_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      tests_run++; tests_failed++;
      $display("FAIL rx_timeout: ready got %b want 1", o_rx_ready);
    end
    @(negedge clk);
  endtask

  task automatic load_block(input logic [W-1:0] v, input int nb, input bit gapped);
    for (int i = 0; i < nb; i++) begin
      send_byte(v[8*(nb-1-i) +: 8]);
      if (gapped && (i % 4 == 1)) begin
        i_rx_valid = 1'b0;
        repeat (2) @(negedge clk);
      end
    end
    i_rx_valid = 1'b0;
  endtask

  // Stub core: flag stale-high through the first wait cycle, result 6 cycles after start.
  task automatic core_respond(input logic [W-1:0] res);
    tests_run++;
    if (o_core_start !== 1'b1 || o_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_pulse: start=%b busy=%b want 1/1", o_core_start, o_busy);
    end
    i_core_a_pow_d  = {128{8'hA5}};
    i_core_finished = 1'b1;
    @(negedge clk);
    tests_run++;
    if (o_core_start !== 1'b0 || o_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_width: start=%b busy=%b want 0/1", o_core_start, o_busy);
    end
    @(negedge clk);
    i_core_finished = 1'b0;
    tests_run++;
    if (o_tx_valid !== 1'b0 || o_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL stale_flag: tx_valid=%b busy=%b want 0/1", o_tx_valid, o_busy);
    end
    repeat (4) @(negedge clk);
    i_core_a_pow_d  = res;
    i_core_finished = 1'b1;
    @(negedge clk);
    tests_run++;
    if (o_tx_valid !== 1'b1 || o_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL finish_latency: tx_valid=%b busy=%b want 1/0", o_tx_valid, o_busy);
    end
  endtask

  task automatic recv_check(input logic [W-1:0] res, input int nb, input bit rnd);
    int idx = 0;
    int t = 0;
    logic stalled = 1'b0;
    logic [7:0] held = 8'h00;
    logic [7:0] exp;
    while (idx < nb && t < 3000) begin
      i_tx_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
      if (o_tx_valid === 1'b1) begin
        if (stalled) begin
          tests_run++;
          if (o_tx_data !== held) begin
            tests_failed++;
            $display("FAIL tx_stable: data got %h want %h", o_tx_data, held);
          end
        end
        if (i_tx_ready) begin
          exp = res[8*(nb-1-idx) +: 8];
          tests_run++;
          if (o_tx_data !== exp) begin
            tests_failed++;
            $display("FAIL tx_byte[%0d]: got %h want %h", idx, o_tx_data, exp);
          end
          idx++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = o_tx_data;
        end
      end else begin
        tests_run++; tests_failed++;
        $display("FAIL tx_valid_drop[%0d]: got %b want 1", idx, o_tx_valid);
      end
      @(negedge clk);
      t++;
    end
    i_tx_ready = 1'b0;
    if (idx < nb) begin
      tests_run++; tests_failed++;
      $display("FAIL tx_timeout: bytes got %0d want %0d", idx, nb);
    end
    tests_run++;
    if (o_tx_valid !== 1'b0 || o_rx_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL tx_end: tx_valid=%b rx_ready=%b want 0/1", o_tx_valid, o_rx_ready);
    end
  endtask

  task automatic do_reset(input logic [10:0] size);
    i_RSA_bit  = size;
    i_rst      = 1'b1;
    i_rx_valid = 1'b0;
    i_tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_bus(input string nm, input logic [W-1:0] got, input logic [W-1:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic test_reset();
    #1 i_rst = 1'b1;
    i_rx_valid = 1'b1;
    i_rx_data  = 8'h55;
    i_tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({o_rx_ready, o_tx_valid, o_tx_data, o_core_start, o_busy} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: rdy=%b txv=%b txd=%h st=%b busy=%b want all 0",
               o_rx_ready, o_tx_valid, o_tx_data, o_core_start, o_busy);
    end
    check_bus("reset_core_a", o_core_a, '0);
    check_bus("reset_core_d", o_core_d, '0);
    check_bus("reset_core_n", o_core_n, '0);
    i_rst = 1'b0;
    #1;
    tests_run++;
    if (o_rx_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_ready: got %b want 0", o_rx_ready);
    end
    @(negedge clk);
    tests_run++;
    if (o_rx_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL get_n_ready: got %b want 1", o_rx_ready);
    end
    i_rx_valid = 1'b0;
    i_tx_ready = 1'b0;
  endtask

  task automatic test_load_128();
    load_block(W'(8'h8F), 16, 1'b0);
    load_block(W'(8'h67), 16, 1'b0);
    for (int i = 0; i < 15; i++) send_byte(8'h00);
    tests_run++;
    if (o_core_start !== 1'b0 || o_rx_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL early_start: start=%b ready=%b want 0/1", o_core_start, o_rx_ready);
    end
    send_byte(8'h02);
    i_rx_valid = 1'b0;
    check_bus("load128_n", o_core_n, W'(8'h8F));
    check_bus("load128_d", o_core_d, W'(8'h67));
    check_bus("load128_a", o_core_a, W'(8'h02));
  endtask

  task automatic test_result();
    logic [W-1:0] res = W'(128'h00112233445566778899AABBCCDDEEFF);
    core_respond(res);
    recv_check(res, 15, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a_bp = W'(128'h3C5A7E9102B4D6F8192A3B4C5D6E7F80);
    logic [W-1:0] res  = W'(128'h00F1E2D3C4B5A6978877665544332211);
    load_block(a_bp, 16, 1'b1);
    check_bus("bp_a", o_core_a, a_bp);
    core_respond(res);
    recv_check(res, 15, 1'b1);
  endtask

  task automatic test_key_reuse();
    logic [W-1:0] res = W'(128'h000102030405060708090A0B0C0D0E0F);
    load_block(W'(8'h05), 16, 1'b0);
    check_bus("reuse_a", o_core_a, W'(8'h05));
    check_bus("reuse_n", o_core_n, W'(8'h8F));
    check_bus("reuse_d", o_core_d, W'(8'h67));
    core_respond(res);
    recv_check(res, 15, 1'b0);
  endtask

  task automatic test_1024_abort();
    logic [W-1:0] n1, d1, a1, r1;
    for (int j = 0; j < 128; j++) begin
      n1[8*j +: 8] = 8'(j) ^ 8'h5A;
      d1[8*j +: 8] = 8'(j + 3);
      a1[8*j +: 8] = 8'hFF - 8'(j);
      r1[8*j +: 8] = (j == 127) ? 8'h00 : 8'(j);
    end
    do_reset(11'd1024);
    load_block(n1, 128, 1'b0);
    load_block(d1, 128, 1'b0);
    load_block(a1, 128, 1'b0);
    check_bus("k1024_n", o_core_n, n1);
    check_bus("k1024_d", o_core_d, d1);
    check_bus("k1024_a", o_core_a, a1);
    core_respond(r1);
    recv_check(r1, 127, 1'b0);
    load_block(a1, 128, 1'b0);
    i_core_finished = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (o_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_pre_busy: got %b want 1", o_busy);
    end
    i_rst = 1'b1;
    #1;
    tests_run++;
    if (o_busy !== 1'b0 || o_core_start !== 1'b0 || o_tx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_ctrl: busy=%b start=%b txv=%b want 0/0/0", o_busy, o_core_start, o_tx_valid);
    end
    check_bus("abort_core_a", o_core_a, '0);
    check_bus("abort_core_d", o_core_d, '0);
    check_bus("abort_core_n", o_core_n, '0);
    repeat (3) @(negedge clk);
    tests_run++;
    if (o_tx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_tx: got %b want 0", o_tx_valid);
    end
  endtask

  task automatic test_illegal_size();
    logic [W-1:0] res = W'(128'h000F0E0D0C0B0A090807060504030201);
    do_reset(11'd300);
    i_RSA_bit = 11'd1024;
    load_block(W'(8'hC3), 16, 1'b0);
    load_block(W'(8'h1D), 16, 1'b0);
    for (int i = 0; i < 15; i++) send_byte(8'h00);
    tests_run++;
    if (o_core_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL illegal_early_start: got %b want 0", o_core_start);
    end
    send_byte(8'h7B);
    i_rx_valid = 1'b0;
    check_bus("illegal_n", o_core_n, W'(8'hC3));
    check_bus("illegal_d", o_core_d, W'(8'h1D));
    check_bus("illegal_a", o_core_a, W'(8'h7B));
    core_respond(res);
    recv_check(res, 15, 1'b0);
  endtask

  initial begin
    test_reset();
    test_load_128();
    test_result();
    test_backpressure();
    test_key_reuse();
    test_1024_abort();
    test_illegal_size();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time got 1000000 want less");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rsa_stream_ctrl.md
Name: rsa_stream_ctrl

Overview:
- Byte-stream front end that initiates and feeds the RSA decryption core. The core is the responder; this block is the initiator.
- Loads modulus N, private key d and ciphertext blocks from an 8-bit valid/ready receive stream, then pulses the core start.
- Waits for the core's finished flag, then returns the plaintext on an 8-bit valid/ready transmit stream.
- Sits between the UART/Avalon byte adapters and the core.

Parameters:
- RSA_BIT_MAX, 1024, width of the key/data buses driven to the core.
- BYTE_CNT_W, 8, width of the byte counter (must hold RSA_BIT_MAX/8).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_RSA_bit  in  11  key size; legal values 128/256/512/1024, any other value is treated as 128
- i_rx_data  in  8  received byte
- i_rx_valid  in  1  received byte valid
- o_rx_ready  out  1  block accepts a byte
- o_tx_data  out  8  plaintext byte
- o_tx_valid  out  1  plaintext byte valid
- i_tx_ready  in  1  sink accepts the byte
- o_core_start  out  1  one-cycle start pulse to the core
- o_core_a  out  RSA_BIT_MAX  ciphertext to the core
- o_core_d  out  RSA_BIT_MAX  private key to the core
- o_core_n  out  RSA_BIT_MAX  modulus to the core
- i_core_a_pow_d  in  RSA_BIT_MAX  core result
- i_core_finished  in  1  core done flag
- o_busy  out  1  high in S_START and S_WAIT

Behaviour:
- Clocking and reset: single clock i_clk; i_rst is asynchronous and active-high.
- On reset: state=S_IDLE; all outputs 0; N/d/a/plaintext registers, byte counter and size register cleared. Reset mid-operation aborts with no further output.
- Transfer rule: a byte transfers on a rising edge when valid&ready.
- o_rx_ready is 1 only in S_GET_N, S_GET_D and S_GET_A.
- o_tx_valid is 1 only in S_SEND. o_tx_data must hold stable while o_tx_valid=1 and i_tx_ready=0.
- BYTES = sampled size/8.
- S_IDLE: latch i_RSA_bit into the size register. Next cycle → S_GET_N, clear N, byte count=0. i_RSA_bit is ignored in all other states.
- S_GET_N:
  - Each accepted byte shifts in: N <= {N[RSA_BIT_MAX-9:0], byte}. Bytes arrive MSB first, so the value ends zero-extended in the low bits.
  - After BYTES bytes → S_GET_D, clear d, count=0.
- S_GET_D: same shifting into d; after BYTES bytes → S_GET_A, clear a, count=0.
- S_GET_A: same shifting into a; after the BYTES-th byte is accepted → S_START.
- S_START:
  - o_core_start=1 for exactly this one cycle, then → S_WAIT.
  - i_core_finished is ignored in this cycle.
- S_WAIT:
  - i_core_finished is ignored in the first S_WAIT cycle; the core's flag may be stale from a previous run.
  - From the second S_WAIT cycle, the first cycle with i_core_finished=1 captures i_core_a_pow_d into the plaintext register and → S_SEND with count=BYTES-2.
- S_SEND:
  - o_tx_data = plaintext[8*count +: 8]. BYTES-1 bytes are emitted, most significant first; byte index BYTES-1 (always 0 for valid plaintext) is dropped.
  - On each accepted byte: if count==0 → S_GET_A (clear a, count=0); else count-1.
- Key persistence: N and d persist across blocks. Only reset reloads the key.
- Core input stability: o_core_a/d/n are driven directly from registers and are unchanged from S_START through S_SEND, because o_rx_ready=0 there.
- i_rx_valid outside the S_GET_* states is not consumed, since ready=0.
- Boundaries:
  - Byte counter wraps never: it compares against BYTES-1 for loads and reaches 0 for sends.
  - Consecutive-cycle transfers (valid/ready held high) are accepted at 1 byte/cycle in every direction.
- Latency:
  - Last a byte accepted at cycle T → o_core_start at T+1.
  - Finished seen at cycle F → first o_tx_valid at F+1.
  - Last tx byte accepted at cycle U → o_rx_ready=1 at U+1.

Test Plan:
- Reset: hold i_rst 3 cycles with i_rx_valid=1 → all outputs 0. One cycle after release o_rx_ready=1; no byte is consumed in S_IDLE.
- 128-bit load: i_RSA_bit=128; send 15×0x00,0x8F / 15×0x00,0x67 / 15×0x00,0x02 → o_core_n=0x8F, o_core_d=0x67, o_core_a=0x02. o_core_start high exactly one cycle, the cycle after the 48th byte; o_busy=1.
- Result return: stub core holds finished=1 from start (stale) and returns 0x00112233445566778899AABBCCDDEEFF at start+6 → stale flag ignored. tx emits 15 bytes 0x11,0x22,…,0xFF; 0x00 dropped.
- Backpressure: random i_tx_ready (≈30% duty) and gapped i_rx_valid → identical byte sequence with no drops or duplicates; o_tx_data stable while stalled.
- Key reuse: after the block, send 16 new ciphertext bytes ending 0x05 → start pulses with o_core_a=0x05; o_core_n/o_core_d unchanged (0x8F/0x67).
- 1024-bit plus abort:
  - i_RSA_bit=1024 → 128 bytes each for N/d/a, 127 tx bytes out.
  - Second run: assert i_rst during S_WAIT → immediately o_busy=0, o_core_start=0, core buses 0, no tx bytes.
- Illegal size: i_RSA_bit=300 → behaves as 128 (16-byte loads, 15-byte output).
